i2c_master_ctrl: RTL and testbench

//  Single-master I2C initiator for the I2C slave-with-memory.

---
 rtl/i2c_master_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C initiator: one command becomes a complete single-byte write or read
// transaction on an open-drain SCL/SDA pair, with a one-cycle response pulse at the end.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_id,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       sda_i
);

    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [1:0] B_ADDR_W = 2'd0;
    localparam logic [1:0] B_MADDR  = 2'd1;
    localparam logic [1:0] B_DATA   = 2'd2;
    localparam logic [1:0] B_ADDR_R = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_TXB,
        S_ACK,
        S_RSTART,
        S_RXB,
        S_MNACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_q;
    logic [2:0]       r_bit;
    logic [1:0]       r_byte;
    logic             r_rw;
    logic [6:0]       r_id;
    logic [7:0]       r_addr;
    logic [7:0]       r_wdata;
    logic [7:0]       r_rx;
    logic             r_nack;
    logic             r_err;
    logic             r_scl;
    logic             r_sda;
    logic             r_ready;
    logic             r_busy;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_rdata;
    logic             r_rsp_err;

    logic             w_tick;
    logic             w_scl;
    logic             w_sda;
    logic [7:0]       w_txbyte;

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign scl_o     = r_scl;
    assign sda_o     = r_sda;

    assign w_tick = (r_state != S_IDLE) && (r_state != S_DONE)
                    && (r_div == DIV_W'(CLK_DIV - 1));

    always_comb begin
        w_txbyte = {r_id, 1'b0};
        case (r_byte)
            B_ADDR_W: w_txbyte = {r_id, 1'b0};
            B_MADDR:  w_txbyte = r_addr;
            B_DATA:   w_txbyte = r_wdata;
            B_ADDR_R: w_txbyte = {r_id, 1'b1};
            default:  w_txbyte = {r_id, 1'b0};
        endcase
    end

    // Line levels for the current quarter; registered below so the pins are glitch-free.
    always_comb begin
        w_scl = 1'b1;
        w_sda = 1'b1;
        case (r_state)
            S_START: begin
                w_scl = (r_q != 2'd3);
                w_sda = (r_q == 2'd0);
            end
            S_RSTART: begin
                w_scl = (r_q == 2'd1) || (r_q == 2'd2);
                w_sda = (r_q <= 2'd1);
            end
            S_STOP: begin
                w_scl = (r_q != 2'd0);
                w_sda = (r_q >= 2'd2);
            end
            S_TXB: begin
                w_scl = r_q[1];
                w_sda = w_txbyte[r_bit];
            end
            S_ACK, S_RXB, S_MNACK: begin
                w_scl = r_q[1];
                w_sda = 1'b1;
            end
            default: begin
                w_scl = 1'b1;
                w_sda = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_q         <= 2'd0;
            r_bit       <= 3'd7;
            r_byte      <= B_ADDR_W;
            r_rw        <= 1'b0;
            r_id        <= 7'd0;
            r_addr      <= 8'd0;
            r_wdata     <= 8'd0;
            r_rx        <= 8'd0;
            r_nack      <= 1'b0;
            r_err       <= 1'b0;
            r_scl       <= 1'b1;
            r_sda       <= 1'b1;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_scl <= w_scl;
            r_sda <= w_sda;

            if ((r_state == S_IDLE) || (r_state == S_DONE) || w_tick)
                r_div <= '0;
            else
                r_div <= r_div + DIV_W'(1);

            case (r_state)
                S_IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (r_rsp_valid) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (cmd_valid && r_ready) begin
                        r_rw        <= cmd_rw;
                        r_id        <= cmd_id;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_err       <= 1'b0;
                        r_nack      <= 1'b0;
                        r_rx        <= 8'd0;
                        r_q         <= 2'd0;
                        r_rsp_rdata <= 8'd0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_START;
                    end
                end
                S_DONE: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= (r_rw && !r_err) ? r_rx : 8'd0;
                    r_rsp_err   <= r_err;
                    r_state     <= S_IDLE;
                end
                default: begin
                    if (w_tick) begin
                        r_q <= r_q + 2'd1;
                        // End of Q2 is the SDA sample point while SCL is high.
                        if (r_q == 2'd2) begin
                            if (r_state == S_ACK)
                                r_nack <= sda_i;
                            if (r_state == S_RXB)
                                r_rx <= {r_rx[6:0], sda_i};
                        end
                        if (r_q == 2'd3) begin
                            case (r_state)
                                S_START: begin
                                    r_byte  <= B_ADDR_W;
                                    r_bit   <= 3'd7;
                                    r_state <= S_TXB;
                                end
                                S_TXB: begin
                                    if (r_bit == 3'd0)
                                        r_state <= S_ACK;
                                    else
                                        r_bit <= r_bit - 3'd1;
                                end
                                S_ACK: begin
                                    r_bit <= 3'd7;
                                    if (r_nack) begin
                                        r_err   <= 1'b1;
                                        r_state <= S_STOP;
                                    end else begin
                                        case (r_byte)
                                            B_ADDR_W: begin
                                                r_byte  <= B_MADDR;
                                                r_state <= S_TXB;
                                            end
                                            B_MADDR: begin
                                                if (r_rw) begin
                                                    r_state <= S_RSTART;
                                                end else begin
                                                    r_byte  <= B_DATA;
                                                    r_state <= S_TXB;
                                                end
                                            end
                                            B_DATA:  r_state <= S_STOP;
                                            default: r_state <= S_RXB;
                                        endcase
                                    end
                                end
                                S_RSTART: begin
                                    r_byte  <= B_ADDR_R;
                                    r_bit   <= 3'd7;
                                    r_state <= S_TXB;
                                end
                                S_RXB: begin
                                    if (r_bit == 3'd0)
                                        r_state <= S_MNACK;
                                    else
                                        r_bit <= r_bit - 3'd1;
                                end
                                S_MNACK: r_state <= S_STOP;
                                S_STOP:  r_state <= S_DONE;
                                default: r_state <= S_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: behavioural I2C memory slave, bus-protocol monitor and
// scoreboards for bus bytes and responses.
module tb_i2c_master_ctrl;

    localparam int         CD     = 4;
    localparam logic [6:0] SLV_ID = 7'h42;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_id = 7'd0;
    logic [7:0] cmd_addr = 8'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       scl_o;
    logic       sda_o;
    logic       sda_i;
    logic       sl_sda = 1'b1;

    assign sda_i = sda_o & sl_sda;

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .scl_o(scl_o), .sda_o(sda_o), .sda_i(sda_i)
    );

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
        int         nst;
    } rsp_t;

    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         rsp_cnt = 0;
    int         n_start = 0;
    int         n_stop = 0;
    logic [7:0] last_rdata = 8'd0;
    logic [7:0] exp_bytes[$];
    rsp_t       rsp_q[$];
    logic [7:0] model_mem[256];
    logic [7:0] smem[256];

    // bus monitor state
    bit   mon_en = 1'b0;
    logic ps = 1'b1, pd = 1'b1;
    int   run_len = 0, lo_len = 0;
    bit   have_hi = 1'b0, have_low = 1'b0, hi_cond = 1'b0, lo_cond_prev = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic rw, input logic [6:0] id, input logic [7:0] addr,
                            input logic [7:0] wd);
        rsp_t r;
        bit   ack;
        int   t;
        @(negedge clk);
        t = 0;
        while (!cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        ack = (id == SLV_ID);
        exp_bytes.push_back({id, 1'b0});
        if (ack) begin
            exp_bytes.push_back(addr);
            exp_bytes.push_back(rw ? {id, 1'b1} : wd);
        end
        r.err   = !ack;
        r.rdata = (ack && rw) ? model_mem[addr] : 8'h00;
        r.lat   = !ack ? 44 * CD + 1 : (rw ? 156 * CD + 1 : 116 * CD + 1);
        r.nst   = (ack && rw) ? 2 : 1;
        if (ack && !rw) model_mem[addr] = wd;
        rsp_q.push_back(r);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_id    = id;
        cmd_addr  = addr;
        cmd_wdata = wd;
        @(posedge clk);
        #1;
        acc_cyc      = cyc;
        cmd_valid    = 1'b0;
        n_start      = 0;
        n_stop       = 0;
        run_len      = 0;
        have_hi      = 1'b0;
        have_low     = 1'b0;
        hi_cond      = 1'b0;
        lo_cond_prev = 1'b1;
        mon_en       = 1'b1;
    endtask

    task automatic wait_rsp();
        int start;
        int t;
        start = rsp_cnt;
        t = 0;
        while (rsp_cnt == start && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("rsp_arrived", 32'(rsp_cnt - start), 32'd1);
        @(negedge clk);
        check("rsp_pulse_end", 32'(rsp_valid), 32'd0);
        check("ready_after", 32'(cmd_ready), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    // Response scoreboard
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_q.size()), 32'd1);
                end else begin
                    r = rsp_q.pop_front();
                    check("latency", 32'(cyc - acc_cyc), 32'(r.lat));
                    check("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
                    check("rsp_err", 32'(rsp_err), 32'(r.err));
                    check("busy_at_rsp", 32'(busy), 32'd1);
                    check("n_start", 32'(n_start), 32'(r.nst));
                    check("n_stop", 32'(n_stop), 32'd1);
                    check("bytes_left", 32'(exp_bytes.size()), 32'd0);
                    last_rdata = r.rdata;
                end
                rsp_cnt++;
            end
        end
    end

    // Bus monitor and memory slave
    initial begin
        logic       s, d;
        logic [7:0] sh, txd, ptr;
        int         bitc, bidx;
        bit         tx, tx_pend, match, ack;
        sh = 8'd0; txd = 8'd0; ptr = 8'd0;
        bitc = 0; bidx = 0; tx = 0; tx_pend = 0; match = 0; ack = 0;
        forever begin
            @(negedge clk);
            s = scl_o;
            d = sda_i;
            if (!rst_n) begin
                sl_sda = 1'b1;
                bitc = 0; bidx = 0; tx = 0; tx_pend = 0; match = 0;
                ps = 1'b1;
                pd = 1'b1;
            end else begin
                if (mon_en) begin
                    if (s && ps && d != pd) begin
                        if (!d) n_start++;
                        else    n_stop++;
                        hi_cond = 1'b1;
                    end
                    if (s != ps) begin
                        if (!s) begin
                            if (have_hi && !hi_cond)
                                check("scl_high_len", 32'(run_len), 32'(2 * CD));
                            if (have_low && !lo_cond_prev && !hi_cond)
                                check("scl_low_len", 32'(lo_len), 32'(2 * CD));
                            lo_cond_prev = hi_cond;
                            hi_cond      = 1'b0;
                            have_low     = 1'b1;
                        end else begin
                            lo_len  = run_len;
                            have_hi = 1'b1;
                        end
                        run_len = 1;
                    end else begin
                        run_len++;
                    end
                end
                if (s && ps && pd && !d) begin
                    bitc = 0; bidx = 0; tx = 0; tx_pend = 0; match = 0;
                    sl_sda = 1'b1;
                end else if (s && ps && !pd && d) begin
                    bitc = 0; bidx = 0; tx = 0; tx_pend = 0; match = 0;
                    sl_sda = 1'b1;
                end else if (!ps && s) begin
                    if (bitc < 8 && !tx) sh = {sh[6:0], d};
                    if (bitc == 8 && tx) check("master_nack", 32'(d), 32'd1);
                    if (bitc < 9) bitc++;
                end else if (ps && !s) begin
                    if (bitc == 8) begin
                        if (!tx) begin
                            if (exp_bytes.size() == 0)
                                check("bus_byte_unexpected", 32'(exp_bytes.size()), 32'd1);
                            else
                                check("bus_byte", 32'(sh), 32'(exp_bytes.pop_front()));
                            if (bidx == 0) begin
                                match   = (sh[7:1] == SLV_ID);
                                tx_pend = match && sh[0];
                            end else if (bidx == 1) begin
                                ptr = sh;
                            end else if (bidx == 2 && match) begin
                                smem[ptr] = sh;
                            end
                            ack    = match;
                            sl_sda = !ack;
                        end else begin
                            sl_sda = 1'b1;
                        end
                    end else if (bitc == 9) begin
                        sl_sda = 1'b1;
                        bitc   = 0;
                        bidx++;
                        if (tx_pend) begin
                            tx      = 1'b1;
                            tx_pend = 1'b0;
                            txd     = smem[ptr];
                            sl_sda  = txd[7];
                        end else begin
                            tx = 1'b0;
                        end
                    end else if (tx && bitc >= 1 && bitc <= 7) begin
                        sl_sda = txd[7 - bitc];
                    end
                end
            end
            ps = s;
            pd = d;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] ra, rd;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 8'd0;
            smem[i]      = 8'd0;
        end

        repeat (3) @(negedge clk);
        check("rst_scl", 32'(scl_o), 32'd1);
        check("rst_sda", 32'(sda_o), 32'd1);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_cmd(1'b0, 7'h42, 8'h10, 8'hA5);
        @(negedge clk);
        check("busy_in_txn", 32'(busy), 32'd1);
        check("ready_in_txn", 32'(cmd_ready), 32'd0);
        wait_rsp();

        send_cmd(1'b1, 7'h42, 8'h10, 8'h00);
        wait_rsp();
        repeat (5) @(negedge clk);
        check("rdata_hold", 32'(rsp_rdata), 32'(last_rdata));

        send_cmd(1'b0, 7'h13, 8'h10, 8'h5A);
        wait_rsp();

        send_cmd(1'b0, 7'h42, 8'h20, 8'h3C);
        cmd_valid = 1'b1;
        cmd_rw    = 1'b1;
        cmd_id    = 7'h13;
        cmd_addr  = 8'hEE;
        cmd_wdata = 8'h11;
        repeat (100) @(negedge clk);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_ready", 32'(cmd_ready), 32'd0);
        repeat (200) @(negedge clk);
        check("hold_busy2", 32'(busy), 32'd1);
        cmd_valid = 1'b0;
        wait_rsp();

        send_cmd(1'b1, 7'h42, 8'h20, 8'h00);
        wait_rsp();

        for (int k = 0; k < 2; k++) begin
            ra = 8'($urandom_range(8'h80, 8'hFF));
            rd = 8'($urandom);
            send_cmd(1'b0, 7'h42, ra, rd);
            wait_rsp();
            send_cmd(1'b1, 7'h42, ra, 8'h00);
            wait_rsp();
        end

        send_cmd(1'b0, 7'h42, 8'h77, 8'h0F);
        repeat ((4 + 36 + 16) * CD) @(negedge clk);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_scl", 32'(scl_o), 32'd1);
        check("midrst_sda", 32'(sda_o), 32'd1);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_bytes.delete();
        rsp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_cmd(1'b0, 7'h42, 8'h55, 8'h99);
        wait_rsp();
        send_cmd(1'b1, 7'h42, 8'h55, 8'h00);
        wait_rsp();

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
